// File: rtl/axi_sram_rd_slave.sv
// AXI4 read-channel responder for a single-port synchronous SRAM with 1-cycle read latency.
// It serves one burst at a time (FIXED/INCR/WRAP) and returns SLVERR beats for illegal requests.
module axi_sram_rd_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 12,
  parameter int STROBE_WIDTH = DATA_WIDTH >> 3
) (
  input  logic                                          aclk,
  input  logic                                          areset,
  input  logic [ID_WIDTH-1:0]                           arid,
  input  logic [ADDR_WIDTH-1:0]                         araddr,
  input  logic [7:0]                                    arlen,
  input  logic [2:0]                                    arsize,
  input  logic [1:0]                                    arburst,
  input  logic                                          arvalid,
  output logic                                          arready,
  output logic [ID_WIDTH-1:0]                           rid,
  output logic [DATA_WIDTH-1:0]                         rdata,
  output logic [1:0]                                    rresp,
  output logic                                          rlast,
  output logic                                          rvalid,
  input  logic                                          rready,
  output logic                                          mem_en,
  output logic [ADDR_WIDTH-$clog2(STROBE_WIDTH)-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]                         mem_rdata
);

  localparam int SW_LOG = $clog2(STROBE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DATA} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            len;
  logic [7:0]            beat;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic                  err;
  logic                  ar_hs;
  logic                  r_hs;

  function automatic logic ar_error(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [7:0]            l,
                                    input logic [2:0]            s,
                                    input logic [1:0]            b);
    logic [ADDR_WIDTH-1:0] nb_mask;
    logic                  e;
    nb_mask = ~({ADDR_WIDTH{1'b1}} << s);
    e = 1'b0;
    if (b == 2'b11) e = 1'b1;
    if (int'(s) > SW_LOG) e = 1'b1;
    if (b == BURST_WRAP && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) e = 1'b1;
    if (b == BURST_WRAP && (addr & nb_mask) != '0) e = 1'b1;
    return e;
  endfunction

  // WRAP windows are power-of-two sized for every legal request, so the
  // lower bound is a simple mask of the current address.
  function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                           input logic [7:0]            l,
                                                           input logic [2:0]            s,
                                                           input logic [1:0]            b);
    logic [ADDR_WIDTH-1:0] nb, aligned, incr, wsize, lower, nxt;
    nb      = ONE << s;
    aligned = addr & ~(nb - ONE);
    incr    = aligned + nb;
    wsize   = (ADDR_WIDTH'(l) + ONE) << s;
    lower   = addr & ~(wsize - ONE);
    case (b)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (incr == lower + wsize) ? lower : incr;
      default:     nxt = incr;
    endcase
    return nxt;
  endfunction

  assign ar_hs     = arvalid && arready && (state == S_IDLE);
  assign r_hs      = rvalid && rready && (state == S_DATA);
  assign next_addr = next_beat_addr(cur_addr, len, size, burst);
  assign mem_en    = (state == S_FETCH) && !err;
  assign mem_addr  = mem_en ? cur_addr[ADDR_WIDTH-1:SW_LOG] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ar_hs) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_DATA;
      S_DATA:  if (r_hs) state_nxt = rlast ? S_IDLE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= S_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      arready <= (state_nxt == S_IDLE);
      case (state)
        S_IDLE: if (ar_hs) rid <= arid;
        // SRAM word issued during FETCH is on mem_rdata now
        S_WAIT: begin
          rvalid <= 1'b1;
          rlast  <= (beat == len);
          rresp  <= err ? RESP_SLVERR : RESP_OKAY;
          rdata  <= err ? '0 : mem_rdata;
        end
        S_DATA: if (rready) begin
          rvalid <= 1'b0;
          rlast  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      cur_addr <= araddr;
      len      <= arlen;
      size     <= arsize;
      burst    <= arburst;
      err      <= ar_error(araddr, arlen, arsize, arburst);
      beat     <= '0;
    end else if (r_hs && !rlast) begin
      beat     <= beat + 8'd1;
      cur_addr <= next_addr;
    end
  end

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Bench for axi_sram_rd_slave: bursts are driven against an SRAM model and each R beat and
// SRAM word address is compared with the reference burst model.
module tb_axi_sram_rd_slave;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [11:0] arid = '0;
  logic [15:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [11:0] rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [11:0] id;
  } rbeat_t;

  rbeat_t      exp_q[$];
  rbeat_t      obs_q[$];
  rbeat_t      stall_q[$];
  logic [13:0] exp_ma[$];
  logic [13:0] obs_ma[$];
  int          obs_cyc[$];
  int          stall_memen;
  int          busy_arready;
  int          checks = 0;
  int          errors = 0;

  axi_sram_rd_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(12)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] memval(input int w);
    return {16'(w) ^ 16'hBEEF, 16'(w) ^ 16'h0F0F};
  endfunction

  always @(posedge aclk) if (mem_en) mem_rdata <= memval(int'(mem_addr));

  task automatic model_burst(input logic [11:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    int a, nb, al, ws, lo, n;
    bit err;
    rbeat_t b;
    nb  = 1 << size;
    err = (burst == 2'b11) || (nb > 4) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
          (burst == 2'b10 && (int'(addr) % nb) != 0);
    a = int'(addr);
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.last = (i == int'(len));
      b.resp = err ? 2'b10 : 2'b00;
      if (err) b.data = '0;
      else begin
        exp_ma.push_back(14'(a >> 2));
        b.data = memval(a >> 2);
      end
      exp_q.push_back(b);
      al = a & ~(nb - 1);
      case (burst)
        2'b00: n = a;
        2'b10: begin
          ws = nb * (int'(len) + 1);
          lo = (a / ws) * ws;
          n  = al + nb;
          if (n == lo + ws) n = lo;
        end
        default: n = al + nb;
      endcase
      a = n & 32'hFFFF;
    end
  endtask

  task automatic drive_burst(input logic [11:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stall_beat, input int stall_cyc);
    int cyc, nbeats, stall_left;
    bit done;
    rbeat_t b;
    exp_q.delete(); obs_q.delete(); exp_ma.delete(); obs_ma.delete();
    obs_cyc.delete(); stall_q.delete();
    stall_memen = 0; busy_arready = 0;
    model_burst(id, addr, len, size, burst);
    @(posedge aclk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1; rready = 1'b1;
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!arready && cyc < 50);
    if (!arready) begin
      checks++; errors++;
      $display("FAIL ar_handshake arready=%0b want 1", arready);
      arvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    arvalid = 1'b0; araddr = ~addr; arid = ~id; arlen = ~len;
    cyc = 0; nbeats = 0; stall_left = stall_cyc; done = 0;
    rready = !(nbeats == stall_beat && stall_left > 0);
    while (!done && cyc < 400) begin
      @(negedge aclk); cyc++;
      if (mem_en) obs_ma.push_back(mem_addr);
      if (arready) busy_arready++;
      b.data = rdata; b.resp = rresp; b.last = rlast; b.id = rid;
      if (rvalid && !rready) begin
        stall_q.push_back(b);
        if (mem_en) stall_memen++;
        stall_left--;
      end
      if (rvalid && rready) begin
        obs_q.push_back(b);
        obs_cyc.push_back(cyc);
        nbeats++;
        if (rlast || nbeats > int'(len)) done = 1;
      end
      @(posedge aclk); #1;
      rready = !(nbeats == stall_beat && stall_left > 0);
    end
    rready = 1'b1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL burst_timeout beats=%0d want %0d", nbeats, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready got %b want 0", arready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    checks++; if ({rlast, rresp, rid, rdata} !== '0) begin
      errors++; $display("FAIL reset_r_outputs got last=%b resp=%b id=%h data=%h want all 0", rlast, rresp, rid, rdata);
    end
    checks++; if ({mem_en, mem_addr} !== '0) begin
      errors++; $display("FAIL reset_mem got en=%b addr=%h want 0", mem_en, mem_addr);
    end
    @(posedge aclk); #1; areset = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_release_arready got %b want 1", arready); end
  endtask

  task automatic test_addressing();
    logic [11:0] ids   [4] = '{12'h123, 12'hABC, 12'h7F0, 12'h001};
    logic [15:0] addrs [4] = '{16'h0010, 16'h0038, 16'h0020, 16'h0003};
    logic [7:0]  lens  [4] = '{8'd3, 8'd3, 8'd2, 8'd2};
    logic [2:0]  sizes [4] = '{3'd2, 3'd2, 3'd2, 3'd0};
    logic [1:0]  bursts[4] = '{2'b01, 2'b10, 2'b00, 2'b01};
    rbeat_t e, o;
    logic [13:0] ea, oa;
    for (int t = 0; t < 4; t++) begin
      drive_burst(ids[t], addrs[t], lens[t], sizes[t], bursts[t], -1, 0);
      checks++; if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL addr%0d beat_count got %0d want %0d", t, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_cyc.size(); k++) begin
        checks++; if (obs_cyc[k] != 3 * (k + 1)) begin
          errors++; $display("FAIL addr%0d latency beat%0d got cycle %0d want %0d", t, k, obs_cyc[k], 3 * (k + 1));
        end
      end
      checks++; if (busy_arready != 0) begin
        errors++; $display("FAIL addr%0d busy_arready got %0d cycles want 0", t, busy_arready);
      end
      for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if (o !== e) begin
          errors++;
          $display("FAIL addr%0d beat%0d got data=%h resp=%0d last=%0d id=%h want data=%h resp=%0d last=%0d id=%h",
                   t, k, o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
        end
      end
      checks++; if (obs_ma.size() != exp_ma.size()) begin
        errors++; $display("FAIL addr%0d mem_en_count got %0d want %0d", t, obs_ma.size(), exp_ma.size());
      end
      for (int k = 0; exp_ma.size() > 0 && obs_ma.size() > 0; k++) begin
        ea = exp_ma.pop_front(); oa = obs_ma.pop_front();
        checks++; if (oa !== ea) begin
          errors++; $display("FAIL addr%0d mem_addr%0d got %0d want %0d", t, k, oa, ea);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rbeat_t e, o, held;
    logic [13:0] ea, oa;
    drive_burst(12'h3C3, 16'h0100, 8'd3, 3'd2, 2'b01, 1, 5);
    held = exp_q[1];
    checks++; if (stall_q.size() != 5) begin
      errors++; $display("FAIL bp_stall_cycles got %0d want 5", stall_q.size());
    end
    for (int k = 0; k < stall_q.size(); k++) begin
      checks++; if (stall_q[k] !== held) begin
        errors++; $display("FAIL bp_stable cycle%0d got data=%h last=%0d want data=%h last=%0d",
                           k, stall_q[k].data, stall_q[k].last, held.data, held.last);
      end
    end
    checks++; if (stall_memen != 0) begin errors++; $display("FAIL bp_mem_en got %0d want 0", stall_memen); end
    checks++; if (busy_arready != 0) begin errors++; $display("FAIL bp_arready got %0d want 0", busy_arready); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_beat_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin
        errors++; $display("FAIL bp_beat%0d got data=%h resp=%0d last=%0d want data=%h resp=%0d last=%0d",
                           k, o.data, o.resp, o.last, e.data, e.resp, e.last);
      end
    end
    for (int k = 0; exp_ma.size() > 0 && obs_ma.size() > 0; k++) begin
      ea = exp_ma.pop_front(); oa = obs_ma.pop_front();
      checks++; if (oa !== ea) begin errors++; $display("FAIL bp_mem_addr%0d got %0d want %0d", k, oa, ea); end
    end
  endtask

  task automatic test_errors();
    logic [15:0] addrs [4] = '{16'h0040, 16'h0000, 16'h0080, 16'h0042};
    logic [7:0]  lens  [4] = '{8'd3, 8'd2, 8'd1, 8'd3};
    logic [2:0]  sizes [4] = '{3'd3, 3'd2, 3'd2, 3'd2};
    logic [1:0]  bursts[4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    rbeat_t e, o;
    for (int t = 0; t < 4; t++) begin
      drive_burst(12'h0E0 + 12'(t), addrs[t], lens[t], sizes[t], bursts[t], -1, 0);
      checks++; if (obs_ma.size() != 0) begin
        errors++; $display("FAIL err%0d mem_en_count got %0d want 0", t, obs_ma.size());
      end
      checks++; if (obs_q.size() != int'(lens[t]) + 1) begin
        errors++; $display("FAIL err%0d beat_count got %0d want %0d", t, obs_q.size(), int'(lens[t]) + 1);
      end
      for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if (o !== e) begin
          errors++; $display("FAIL err%0d beat%0d got data=%h resp=%0d last=%0d id=%h want data=%h resp=%0d last=%0d id=%h",
                             t, k, o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    rbeat_t e, o;
    @(posedge aclk); #1;
    arid = 12'h5A5; araddr = 16'h0200; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1; rready = 1'b1;
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!arready && cyc < 50);
    @(posedge aclk); #1; arvalid = 1'b0;
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!rvalid && cyc < 50);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL abort_first_beat rvalid=%b want 1", rvalid); end
    @(posedge aclk); #1;
    @(posedge aclk); #1; areset = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++; if ({rvalid, mem_en, arready, rlast} !== 4'b0000) begin
      errors++; $display("FAIL abort_outputs got rvalid=%b mem_en=%b arready=%b rlast=%b want 0000",
                         rvalid, mem_en, arready, rlast);
    end
    @(posedge aclk); #1; areset = 1'b0;
    @(negedge aclk);
    checks++; if ({rvalid, mem_en} !== 2'b00) begin
      errors++; $display("FAIL abort_quiet got rvalid=%b mem_en=%b want 00", rvalid, mem_en);
    end
    @(negedge aclk);
    checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL abort_rearm got arready=%b rvalid=%b want arready=1 rvalid=0", arready, rvalid);
    end
    drive_burst(12'h6B6, 16'h0300, 8'd1, 3'd2, 2'b01, -1, 0);
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_new_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin
        errors++; $display("FAIL abort_new_beat%0d got data=%h resp=%0d last=%0d want data=%h resp=%0d last=%0d",
                           k, o.data, o.resp, o.last, e.data, e.resp, e.last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addressing();
    test_backpressure();
    test_errors();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
